// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data access) for one single-ported memory.
// Data normally wins; a fetch that has been denied STARVE_LIMIT cycles in a row is forced through.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_async,
  input  logic        fetch_req,
  input  logic [19:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [19:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic [19:0] mem_address,
  input  logic [31:0] mem_read_value,
  output logic        mem_write_en,
  output logic [31:0] mem_write_value,
  output logic        starving
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_FETCH = 2'b01,
    TAG_DATA  = 2'b10
  } tag_e;

  tag_e          tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          starving_q;
  logic          force_fetch_s;
  logic          fetch_gnt_s;
  logic          data_gnt_s;

  // Grant selection; reset blocks every grant so nothing reaches memory.
  always_comb begin
    force_fetch_s = fetch_req && (cnt_q == LIMIT_C);
    fetch_gnt_s   = 1'b0;
    data_gnt_s    = 1'b0;
    if (!rst_async) begin
      fetch_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end else if (data_req && !force_fetch_s) begin
      data_gnt_s = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt_s = 1'b1;
    end else begin
      fetch_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end
  end

  // Memory port steering from the winning requester.
  always_comb begin
    mem_address     = 20'h00000;
    mem_write_en    = 1'b0;
    mem_write_value = 32'h0000_0000;
    if (data_gnt_s) begin
      mem_address = data_addr;
      if (data_we) begin
        mem_write_en    = 1'b1;
        mem_write_value = data_wdata;
      end else begin
        mem_write_en    = 1'b0;
        mem_write_value = 32'h0000_0000;
      end
    end else if (fetch_gnt_s) begin
      mem_address = fetch_addr;
    end else begin
      mem_address = 20'h00000;
    end
  end

  // Response tag and starve counter next-state; writes produce no response.
  always_comb begin
    tag_d = TAG_NONE;
    cnt_d = '0;
    case ({fetch_gnt_s, data_gnt_s})
      2'b10:   tag_d = TAG_FETCH;
      2'b01:   tag_d = data_we ? TAG_NONE : TAG_DATA;
      default: tag_d = TAG_NONE;
    endcase
    if (fetch_req && !fetch_gnt_s) begin
      cnt_d = (cnt_q == LIMIT_C) ? cnt_q : (cnt_q + CW'(1));
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_async) begin
      tag_q      <= TAG_NONE;
      cnt_q      <= '0;
      starving_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      starving_q <= (cnt_d == LIMIT_C);
    end
  end

  // An in-flight response is dropped as soon as reset is seen.
  always_comb begin
    fetch_rvalid = rst_async && (tag_q == TAG_FETCH);
    data_rvalid  = rst_async && (tag_q == TAG_DATA);
    fetch_rdata  = fetch_rvalid ? mem_read_value : 32'h0000_0000;
    data_rdata   = data_rvalid  ? mem_read_value : 32'h0000_0000;
  end

  assign fetch_gnt = fetch_gnt_s;
  assign data_gnt  = data_gnt_s;
  assign starving  = starving_q;

  mem_arbiter_chk u_chk (
    .clk          (clk),
    .fetch_gnt    (fetch_gnt_s),
    .data_gnt     (data_gnt_s),
    .mem_write_en (mem_write_en),
    .fetch_rvalid (fetch_rvalid),
    .data_rvalid  (data_rvalid)
  );

endmodule

// Invariants of the arbiter outputs, checked every clock.
module mem_arbiter_chk (
  input logic clk,
  input logic fetch_gnt,
  input logic data_gnt,
  input logic mem_write_en,
  input logic fetch_rvalid,
  input logic data_rvalid
);

  a_one_grant: assert property (@(posedge clk) !(fetch_gnt && data_gnt));
  a_write_needs_gnt: assert property (@(posedge clk) !(mem_write_en && !data_gnt));
  a_one_rvalid: assert property (@(posedge clk) !(fetch_rvalid && data_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table, then model-checked alternating and random traffic.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        rst;
    logic        freq;
    logic [19:0] faddr;
    logic        dreq;
    logic        dwe;
    logic [19:0] daddr;
    logic [31:0] wdata;
    logic [31:0] rv;
  } in_t;

  typedef struct packed {
    logic        fg;
    logic        dg;
    logic [19:0] addr;
    logic        we;
    logic [31:0] wv;
    logic        frv;
    logic        drv;
    logic [31:0] frd;
    logic [31:0] drd;
    logic        st;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  typedef struct {
    bit is_fetch;
    int due;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_async, fetch_req, data_req, data_we;
  logic [19:0] fetch_addr, data_addr;
  logic [31:0] data_wdata, mem_read_value;
  logic        fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, mem_write_en, starving;
  logic [31:0] fetch_rdata, data_rdata, mem_write_value;
  logic [19:0] mem_address;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int denied = 0;
  resp_t resp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_async(rst_async),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_read_value(mem_read_value),
    .mem_write_en(mem_write_en), .mem_write_value(mem_write_value), .starving(starving)
  );

  function automatic vec_t row(input logic r, fr, input logic [19:0] fa, input logic dr, dw,
                               input logic [19:0] da, input logic [31:0] wd, rv,
                               input logic fg, dg, input logic [19:0] ad, input logic we,
                               input logic [31:0] wv, input logic frv, drv,
                               input logic [31:0] frd, drd, input logic st);
    vec_t v;
    v.i = '{rst: r, freq: fr, faddr: fa, dreq: dr, dwe: dw, daddr: da, wdata: wd, rv: rv};
    v.e = '{fg: fg, dg: dg, addr: ad, we: we, wv: wv, frv: frv, drv: drv,
            frd: frd, drd: drd, st: st};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  // Reference behaviour: priority rule, starve count of consecutive denials, queue of pending reads.
  function automatic out_t model(input in_t i);
    out_t o;
    bit forced;
    o = '0;
    forced = i.freq && (denied == LIMIT);
    if (i.rst) begin
      o.dg = i.dreq && !forced;
      o.fg = i.freq && !o.dg;
    end
    o.addr = o.fg ? i.faddr : (o.dg ? i.daddr : 20'h00000);
    o.we   = o.dg && i.dwe;
    o.wv   = o.we ? i.wdata : 32'h0000_0000;
    foreach (resp_q[k]) begin
      if (resp_q[k].due == cyc && i.rst) begin
        if (resp_q[k].is_fetch) begin o.frv = 1'b1; o.frd = i.rv; end
        else begin o.drv = 1'b1; o.drd = i.rv; end
      end
    end
    o.st = (denied == LIMIT);
    return o;
  endfunction

  task automatic model_update(input in_t i, input out_t o);
    resp_t r;
    while (resp_q.size() > 0 && resp_q[0].due <= cyc) void'(resp_q.pop_front());
    if (!i.rst) begin
      denied = 0;
      resp_q.delete();
    end else begin
      denied = (i.freq && !o.fg) ? ((denied + 1 > LIMIT) ? LIMIT : denied + 1) : 0;
      if (o.fg) begin r.is_fetch = 1'b1; r.due = cyc + 1; resp_q.push_back(r); end
      if (o.dg && !i.dwe) begin r.is_fetch = 1'b0; r.due = cyc + 1; resp_q.push_back(r); end
    end
  endtask

  task automatic compare(input out_t e);
    chk("fetch_gnt", {31'h0, fetch_gnt}, {31'h0, e.fg});
    chk("data_gnt", {31'h0, data_gnt}, {31'h0, e.dg});
    chk("mem_address", {12'h000, mem_address}, {12'h000, e.addr});
    chk("mem_write_en", {31'h0, mem_write_en}, {31'h0, e.we});
    chk("mem_write_value", mem_write_value, e.wv);
    chk("fetch_rvalid", {31'h0, fetch_rvalid}, {31'h0, e.frv});
    chk("data_rvalid", {31'h0, data_rvalid}, {31'h0, e.drv});
    chk("fetch_rdata", fetch_rdata, e.frd);
    chk("data_rdata", data_rdata, e.drd);
    chk("starving", {31'h0, starving}, {31'h0, e.st});
  endtask

  // One cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic apply(input in_t i, input bit use_tbl, input out_t tbl);
    out_t m;
    rst_async = i.rst; fetch_req = i.freq; fetch_addr = i.faddr;
    data_req = i.dreq; data_we = i.dwe; data_addr = i.daddr;
    data_wdata = i.wdata; mem_read_value = i.rv;
    @(negedge clk);
    m = model(i);
    compare(use_tbl ? tbl : m);
    @(posedge clk);
    model_update(i, m);
    cyc++;
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t  in;
    rst_async = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = 20'h00000; data_addr = 20'h00000;
    data_wdata = 32'h0; mem_read_value = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    //          rst fr faddr     dr dw daddr     wdata          rv             fg dg addr      we wv             frv drv frd            drd            st
    tbl.push_back(row(0,1,20'h00010,1,1,20'h00200,32'hAAAA_AAAA,32'h0,         0,0,20'h00000,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,1,20'h00010,0,0,20'h00000,32'h0,        32'h0,         1,0,20'h00010,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,0,20'h00000,0,0,20'h00000,32'h0,        32'hDEAD_BEEF, 0,0,20'h00000,0,32'h0,         1,0,32'hDEAD_BEEF, 32'h0,         0));
    tbl.push_back(row(1,1,20'h00020,1,0,20'h00100,32'h0,        32'h0,         0,1,20'h00100,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,0,20'h00000,0,0,20'h00000,32'h0,        32'hCAFE_F00D, 0,0,20'h00000,0,32'h0,         0,1,32'h0,         32'hCAFE_F00D, 0));
    tbl.push_back(row(1,0,20'h00000,1,1,20'h00200,32'h1234_5678,32'h0,         0,1,20'h00200,1,32'h1234_5678, 0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,0,20'h00000,0,0,20'h00000,32'h0,        32'h5555_5555, 0,0,20'h00000,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,0,20'h00000,1,0,20'h00300,32'h0,        32'h0,         0,1,20'h00300,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(0,0,20'h00000,1,1,20'h00400,32'hFFFF_0000,32'h1111_1111, 0,0,20'h00000,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(0,0,20'h00000,1,1,20'h00400,32'hFFFF_0000,32'h1111_1111, 0,0,20'h00000,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,0,20'h00000,0,0,20'h00000,32'h0,        32'h2222_2222, 0,0,20'h00000,0,32'h0,         0,0,32'h0,         32'h0,         0));
    // Fetch and data held together: four data wins, then the starved fetch is forced through.
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 0,1,20'h00500,0,32'h0,         0,0,32'h0,         32'h0,         0));
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 0,1,20'h00500,0,32'h0,         0,1,32'h0,         32'hA5A5_A5A5, 0));
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 0,1,20'h00500,0,32'h0,         0,1,32'h0,         32'hA5A5_A5A5, 0));
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 0,1,20'h00500,0,32'h0,         0,1,32'h0,         32'hA5A5_A5A5, 0));
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 1,0,20'h00F00,0,32'h0,         0,1,32'h0,         32'hA5A5_A5A5, 1));
    tbl.push_back(row(1,1,20'h00F00,1,0,20'h00500,32'h0,        32'hA5A5_A5A5, 0,1,20'h00500,0,32'h0,         1,0,32'hA5A5_A5A5, 32'h0,         0));

    foreach (tbl[k]) apply(tbl[k].i, 1'b1, tbl[k].e);

    // Alternating fetch / data reads, plus one idle cycle to collect the last response.
    for (int k = 0; k < 9; k++) begin
      in = '0;
      in.rst = 1'b1;
      in.rv  = 32'h0BAD_0000 + k;
      if (k < 8) begin
        if (k % 2 == 0) begin in.freq = 1'b1; in.faddr = 20'h01000 + k; end
        else begin in.dreq = 1'b1; in.daddr = 20'h02000 + k; end
      end
      apply(in, 1'b0, '0);
    end

    for (int k = 0; k < 400; k++) begin
      in.rst   = ($urandom_range(0, 15) != 0);
      in.freq  = ($urandom_range(0, 9) < 6);
      in.dreq  = ($urandom_range(0, 9) < 7);
      in.dwe   = ($urandom_range(0, 9) < 3);
      in.faddr = 20'($urandom);
      in.daddr = 20'($urandom);
      in.wdata = $urandom;
      in.rv    = $urandom;
      apply(in, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied fetch cycles before fetch is forced to win.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_async  input  1  reset, synchronous and active-low (sampled on clk rising edge; 0 = reset).
REQ-004 SHALL have port fetch_req  input  1  instruction fetcher requests a read this cycle.
REQ-005 SHALL have port fetch_addr  input  20  fetch word address.
REQ-006 SHALL have port fetch_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port fetch_rvalid  output  1  fetch read data valid.
REQ-008 SHALL have port fetch_rdata  output  32  fetch read data.
REQ-009 SHALL have port data_req  input  1  data-access stage requests a read or write this cycle.
REQ-010 SHALL have port data_we  input  1  1 = write, 0 = read, qualified by data_req.
REQ-011 SHALL have port data_addr  input  20  data word address.
REQ-012 SHALL have port data_wdata  input  32  write data.
REQ-013 SHALL have port data_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port data_rvalid  output  1  data read data valid.
REQ-015 SHALL have port data_rdata  output  32  data read data.
REQ-016 SHALL have port mem_address  output  20  single-ported memory address.
REQ-017 SHALL have port mem_read_value  input  32  memory read data, one cycle after address.
REQ-018 SHALL have port mem_write_en  output  1  memory write strobe.
REQ-019 SHALL have port mem_write_value  output  32  memory write data.
REQ-020 SHALL have port starving  output  1  starve counter has reached STARVE_LIMIT.

Function
REQ-021 SHALL grant at most one requester per cycle; fetch_gnt and data_gnt are combinational from requests and registered state, never both 1.
REQ-022 SHALL grant data when data_req=1, unless fetch_req=1 and starve counter == STARVE_LIMIT, in which case fetch is granted.
REQ-023 SHALL grant fetch when fetch_req=1 and data_req=0.
REQ-024 SHALL drive mem_address = granted requester's address, or 20'h0 when no grant.
REQ-025 SHALL drive mem_write_en=1 and mem_write_value=data_wdata only when data_gnt=1 and data_we=1; otherwise 0 and 32'h0.
REQ-026 SHALL keep a 2-bit registered response tag with states NONE, FETCH, DATA: next = FETCH on fetch grant, DATA on data read grant, NONE otherwise (including data write grant).
REQ-027 SHALL assert fetch_rvalid when tag==FETCH and data_rvalid when tag==DATA, exactly one cycle after the grant; read latency is 1 cycle.
REQ-028 SHALL drive fetch_rdata/data_rdata = mem_read_value while its rvalid is 1, else 32'h0.
REQ-029 SHALL never assert an rvalid for a write.
REQ-030 SHALL support back-to-back grants every cycle to either requester with no idle bubble; response of cycle N and grant of cycle N+1 coexist.
REQ-031 SHALL hold a starve counter (width clog2(STARVE_LIMIT+1)): +1 when fetch_req=1 and fetch_gnt=0, saturating at STARVE_LIMIT; cleared to 0 when fetch_gnt=1 or fetch_req=0.
REQ-032 SHALL drive starving = (counter == STARVE_LIMIT), registered.
REQ-033 SHALL treat a requester that deasserts req before grant as withdrawn; no state is kept for it.

Reset
REQ-034 SHALL, while rst_async==0 at a rising edge, set tag=NONE and counter=0.
REQ-035 SHALL force fetch_gnt=0, data_gnt=0, mem_write_en=0 combinationally while rst_async==0, so no write commits during reset.
REQ-036 SHALL drop any in-flight response when reset is asserted mid-operation; the cycle after reset release has fetch_rvalid=data_rvalid=0 and all data/address outputs 0.

Verification
REQ-037 SHALL cover: fetch_req only, fetch_addr=20'h00010, memory returns 32'hDEADBEEF -> fetch_gnt same cycle, next cycle fetch_rvalid=1, fetch_rdata=32'hDEADBEEF.
REQ-038 SHALL cover: fetch_req and data_req (read, addr 20'h00100) together -> data_gnt=1, fetch_gnt=0, mem_address=20'h00100; next cycle data_rvalid=1, fetch_rvalid=0.
REQ-039 SHALL cover: data write addr 20'h00200, wdata 32'h12345678 -> mem_write_en=1, mem_write_value=32'h12345678 same cycle; no rvalid next cycle.
REQ-040 SHALL cover: data_req and fetch_req held high continuously, STARVE_LIMIT=4 -> data granted 4 cycles, starving=1 in cycle 5 with fetch_gnt=1, counter back to 0, data granted cycle 6.
REQ-041 SHALL cover: rst_async driven 0 in the cycle after a data read grant -> no data_rvalid; mem_write_en=0 throughout reset even with data_we=1.
REQ-042 SHALL cover: alternating fetch/data read grants for 8 cycles -> each rvalid routed to correct requester, one per cycle, no loss.
